// File: rtl/dmem_port_pkg.sv
// Shared types and constants for the M-stage data-memory port.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RDONE = 2'd3
  } dmem_state_e;

  localparam int TIMEOUT_DEFAULT = 255;

  // Data handed back to a load whose bus read was abandoned.
  localparam logic [31:0] BUS_ERR_RDATA = 32'h0;

endpackage

// File: rtl/dmem_port_if.sv
// Single-outstanding-request data bus between the memory port and memory.
interface dmem_bus_if;
  logic        req;
  logic        we;
  logic [29:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_port_wbuf1.sv
// One-entry posted write buffer with word-address hit compare.
module wbuf1 (
  input  logic        clk,
  input  logic        reset,
  input  logic        cap,
  input  logic        clr,
  input  logic [29:0] cap_addr,
  input  logic [31:0] cap_data,
  input  logic [29:0] look_addr,
  output logic        valid,
  output logic [29:0] addr,
  output logic [31:0] data,
  output logic        hit
);

  // Capture only happens while empty and clear only while full, so the two never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (cap) begin
      valid <= 1'b1;
      addr  <= cap_addr;
      data  <= cap_data;
    end else if (clr) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == look_addr);

endmodule

// File: rtl/dmem_port.sv
// M-stage data-memory port: posted write buffer, load forwarding, bus sequencing.
module dmem_port
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memreadm,
  input  logic        memwritem,
  input  logic [31:0] aluoutm,
  input  logic [31:0] writedatam,
  output logic [31:0] readdatam,
  output logic        memstallm,
  output logic        addr_exc,
  output logic        bus_err,
  dmem_bus_if.master  bus
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  dmem_state_e state;
  logic [CW-1:0] tmo_cnt;
  logic [31:0]   rdata_q;

  logic        misal, store_ok, load_ok;
  logic [29:0] word;
  logic        wb_valid, wb_hit, wb_cap, wb_clr;
  logic [29:0] wb_addr;
  logic [31:0] wb_data;
  logic        tmo_hit;

  assign word     = aluoutm[31:2];
  assign misal    = (memreadm || memwritem) && (aluoutm[1:0] != 2'b00);
  assign store_ok = memwritem && !misal;
  assign load_ok  = memreadm && !memwritem && !misal;

  // Counter holds the number of request cycles already spent without an ack;
  // the request is abandoned at the end of its TIMEOUT-th cycle.
  assign tmo_hit  = (tmo_cnt == CW'(TIMEOUT - 1));

  assign wb_cap   = !reset && store_ok && !wb_valid;
  assign wb_clr   = (state == WRITE) && (bus.ack || tmo_hit);

  wbuf1 u_wbuf (
    .clk       (clk),
    .reset     (reset),
    .cap       (wb_cap),
    .clr       (wb_clr),
    .cap_addr  (word),
    .cap_data  (writedatam),
    .look_addr (word),
    .valid     (wb_valid),
    .addr      (wb_addr),
    .data      (wb_data),
    .hit       (wb_hit)
  );

  assign addr_exc = !reset && misal;

  // Stall and load-return path: forwarding from wbuf, latched bus data in RDONE.
  always_comb begin
    memstallm = 1'b0;
    readdatam = '0;
    if (!reset) begin
      if (store_ok) begin
        memstallm = wb_valid;
      end else if (load_ok) begin
        if (state == RDONE)  readdatam = rdata_q;
        else if (wb_hit)     readdatam = wb_data;
        else                 memstallm = 1'b1;
      end
    end
  end

  // Bus sequencer: a pending drain always goes before a missing load; a store
  // arriving to an empty buffer starts its drain straight from the pipeline inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      rdata_q   <= '0;
      bus_err   <= 1'b0;
      bus.req   <= 1'b0;
      bus.we    <= 1'b0;
      bus.addr  <= '0;
      bus.wdata <= '0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          tmo_cnt <= '0;
          if (wb_valid) begin
            state     <= WRITE;
            bus.req   <= 1'b1;
            bus.we    <= 1'b1;
            bus.addr  <= wb_addr;
            bus.wdata <= wb_data;
          end else if (store_ok) begin
            state     <= WRITE;
            bus.req   <= 1'b1;
            bus.we    <= 1'b1;
            bus.addr  <= word;
            bus.wdata <= writedatam;
          end else if (load_ok) begin
            state    <= READ;
            bus.req  <= 1'b1;
            bus.we   <= 1'b0;
            bus.addr <= word;
          end
        end
        WRITE: begin
          if (bus.ack || tmo_hit) begin
            state   <= IDLE;
            bus.req <= 1'b0;
            bus_err <= !bus.ack;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        READ: begin
          if (bus.ack) begin
            state   <= RDONE;
            bus.req <= 1'b0;
            rdata_q <= bus.rdata;
          end else if (tmo_hit) begin
            state   <= RDONE;
            bus.req <= 1'b0;
            bus_err <= 1'b1;
            rdata_q <= BUS_ERR_RDATA;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RDONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: directed scenarios plus a randomized load/store mix.
module tb_dmem_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        memreadm, memwritem;
  logic [31:0] aluoutm, writedatam;
  logic [31:0] readdatam;
  logic        memstallm, addr_exc, bus_err;

  dmem_bus_if bus ();

  dmem_port #(.TIMEOUT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .memreadm   (memreadm),
    .memwritem  (memwritem),
    .aluoutm    (aluoutm),
    .writedatam (writedatam),
    .readdatam  (readdatam),
    .memstallm  (memstallm),
    .addr_exc   (addr_exc),
    .bus_err    (bus_err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] a;
    logic [31:0] d;
  } wr_t;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_load [$];
  wr_t         exp_wr [$];
  logic [31:0] ref_mem [logic [29:0]];
  logic [31:0] mem_s   [logic [29:0]];

  logic [29:0] cur_load_word;
  int  lat = 1;
  bit  ack_en = 1'b1;
  int  hold = 0;
  int  last_len = 0;
  int  n_rd_seen = 0;
  int  n_wr_seen = 0;
  int  n_err_pulse = 0;
  logic [29:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [29:0] w);
    return {w, 2'b00} ^ 32'h5A5A_0000;
  endfunction

  // Architectural view: a load returns the latest store to its word in program order.
  function automatic logic [31:0] model_rd(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  // Memory slave: acks after `lat` request cycles, checks bus stability and write order.
  always @(negedge clk) begin
    if (reset || !bus.req) begin
      if (hold > 0) last_len = hold;
      hold = 0;
      bus.ack = 1'b0;
    end else begin
      if (hold == 0) begin
        s_addr  = bus.addr;
        s_we    = bus.we;
        s_wdata = bus.wdata;
      end else begin
        chk("bus_addr_stable", {2'b00, bus.addr}, {2'b00, s_addr});
        chk("bus_we_stable", {31'b0, bus.we}, {31'b0, s_we});
        if (s_we) chk("bus_wdata_stable", bus.wdata, s_wdata);
      end
      hold++;
      if (ack_en && hold >= lat) begin
        bus.ack = 1'b1;
        if (bus.we) begin
          mem_s[bus.addr] = bus.wdata;
          n_wr_seen++;
          if (exp_wr.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
          else begin
            wr_t e;
            e = exp_wr.pop_front();
            chk("wr_addr", {2'b00, bus.addr}, {2'b00, e.a});
            chk("wr_data", bus.wdata, e.d);
          end
        end else begin
          bus.rdata = mem_s.exists(bus.addr) ? mem_s[bus.addr] : init_word(bus.addr);
          n_rd_seen++;
          chk("rd_addr", {2'b00, bus.addr}, {2'b00, cur_load_word});
        end
      end else begin
        bus.ack = 1'b0;
      end
    end
  end

  // Load-result monitor: pops an expectation whenever an aligned load completes.
  always @(negedge clk) begin
    if (!reset && memreadm && !memwritem && aluoutm[1:0] == 2'b00 && !memstallm) begin
      if (exp_load.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
      else chk("load_data", readdatam, exp_load.pop_front());
    end
  end

  always @(negedge clk) if (!reset && bus_err) n_err_pulse++;

  task automatic do_op(input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input bit track, output int stall);
    bit mis;
    logic [29:0] w;
    wr_t e;
    mis = (rd || wr) && (a[1:0] != 2'b00);
    w   = a[31:2];
    memreadm = rd; memwritem = wr; aluoutm = a; writedatam = d;
    if (rd && !wr && !mis) cur_load_word = w;
    if (track && !mis) begin
      if (wr) begin
        ref_mem[w] = d;
        e.a = w; e.d = d;
        exp_wr.push_back(e);
      end else if (rd) begin
        exp_load.push_back(model_rd(w));
      end
    end
    stall = 0;
    @(negedge clk);
    while (memstallm === 1'b1 && stall < 100) begin
      stall++;
      @(negedge clk);
    end
    if (stall >= 100) chk("stall_bound", 32'd1, 32'd0);
    chk("addr_exc", {31'b0, addr_exc}, {31'b0, mis});
    if (mis) chk("misal_rdata", readdatam, 32'h0);
    @(posedge clk); #1;
    memreadm = 1'b0; memwritem = 1'b0;
  endtask

  task automatic settle();
    int quiet = 0;
    int n = 0;
    while (quiet < 2 && n < 300) begin
      @(negedge clk);
      n++;
      if (bus.req) quiet = 0; else quiet++;
    end
    if (quiet < 2) chk("settle_bound", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_readdatam"}, readdatam, 32'h0);
    chk({tag, "_memstallm"}, {31'b0, memstallm}, 32'h0);
    chk({tag, "_addr_exc"}, {31'b0, addr_exc}, 32'h0);
    chk({tag, "_bus_err"}, {31'b0, bus_err}, 32'h0);
    chk({tag, "_bus_req"}, {31'b0, bus.req}, 32'h0);
    chk({tag, "_bus_we"}, {31'b0, bus.we}, 32'h0);
    chk({tag, "_bus_addr"}, {2'b00, bus.addr}, 32'h0);
    chk({tag, "_bus_wdata"}, bus.wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, rd0, e0, kind;
    logic [31:0] a;
    reset = 1'b1; memreadm = 1'b0; memwritem = 1'b0;
    aluoutm = '0; writedatam = '0; cur_load_word = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    // Load miss, ack on the third request cycle.
    mem_s[30'h40] = 32'hCAFEF00D; ref_mem[30'h40] = 32'hCAFEF00D;
    lat = 3;
    do_op(1'b1, 1'b0, 32'h100, 32'h0, 1'b1, st);
    chk("t1_stall", st, 32'd4);
    settle();

    // Store to empty buffer: no stall, drain request the next cycle.
    do_op(1'b0, 1'b1, 32'h208, 32'h55AA55AA, 1'b1, st);
    chk("t2a_stall", st, 32'd0);
    @(negedge clk);
    chk("t2a_req", {31'b0, bus.req}, 32'd1);
    chk("t2a_we", {31'b0, bus.we}, 32'd1);
    chk("t2a_addr", {2'b00, bus.addr}, 32'h82);
    chk("t2a_wdata", bus.wdata, 32'h55AA55AA);
    settle();

    // Store then load of the same word: forwarded, no bus read.
    rd0 = n_rd_seen;
    do_op(1'b0, 1'b1, 32'h200, 32'h11223344, 1'b1, st);
    do_op(1'b1, 1'b0, 32'h200, 32'h0, 1'b1, st);
    chk("t2_hit_stall", st, 32'd0);
    settle();
    chk("t2_no_read", n_rd_seen, rd0);

    // Store then load of another word: waits for the drain, then reads word 0x81.
    lat = 2;
    do_op(1'b0, 1'b1, 32'h200, 32'h99887766, 1'b1, st);
    do_op(1'b1, 1'b0, 32'h204, 32'h0, 1'b1, st);
    chk("t3_stall", st, 32'd5);
    settle();

    // Back-to-back stores: second waits for the first drain ack.
    do_op(1'b0, 1'b1, 32'h300, 32'hA0A0A0A0, 1'b1, st);
    chk("t4_first_stall", st, 32'd0);
    do_op(1'b0, 1'b1, 32'h304, 32'hB1B1B1B1, 1'b1, st);
    chk("t4_second_stall", st, 32'd2);
    settle();
    chk("t4_wr_drained", exp_wr.size(), 32'd0);

    // Misaligned load and store.
    rd0 = n_rd_seen;
    do_op(1'b1, 1'b0, 32'h103, 32'h0, 1'b1, st);
    chk("t5_stall", st, 32'd0);
    @(negedge clk);
    chk("t5_no_req", {31'b0, bus.req}, 32'd0);
    do_op(1'b0, 1'b1, 32'h202, 32'hDEADDEAD, 1'b1, st);
    chk("t5s_stall", st, 32'd0);
    settle();
    chk("t5_no_read", n_rd_seen, rd0);

    // Read timeout with TIMEOUT = 8.
    ack_en = 1'b0;
    e0 = n_err_pulse;
    exp_load.push_back(32'h0);
    do_op(1'b1, 1'b0, 32'h500, 32'h0, 1'b0, st);
    chk("t6_stall", st, 32'd9);
    chk("t6_req_len", last_len, 32'd8);
    settle();
    chk("t6_err_pulses", n_err_pulse - e0, 32'd1);

    // Reset in the middle of a read.
    memreadm = 1'b1; aluoutm = 32'h600;
    @(negedge clk);
    @(negedge clk);
    chk("t7_req_up", {31'b0, bus.req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; memreadm = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("t7");
    @(posedge clk); #1;
    reset = 1'b0;

    // Reset during a write drain discards the buffered store.
    do_op(1'b0, 1'b1, 32'h400, 32'hFEEDFACE, 1'b0, st);
    @(negedge clk);
    chk("t8_req_up", {31'b0, bus.req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t8_req_down", {31'b0, bus.req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    ack_en = 1'b1; lat = 1;
    do_op(1'b1, 1'b0, 32'h400, 32'h0, 1'b1, st);
    settle();

    // Randomized mix over a small address window to exercise hits and drains.
    for (int i = 0; i < 200; i++) begin
      lat  = $urandom_range(1, 5);
      kind = $urandom_range(0, 9);
      a    = 32'h200 + 32'($urandom_range(0, 7)) * 4;
      case (kind)
        0, 1, 2, 3: do_op(1'b1, 1'b0, a, 32'h0, 1'b1, st);
        4, 5, 6:    do_op(1'b0, 1'b1, a, $urandom, 1'b1, st);
        7:          do_op(1'b1, 1'b1, a, $urandom, 1'b1, st);
        8:          do_op(1'b1, 1'b0, a + 32'($urandom_range(1, 3)), 32'h0, 1'b1, st);
        default:    do_op(1'b0, 1'b1, a + 32'($urandom_range(1, 3)), $urandom, 1'b1, st);
      endcase
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
      end
    end
    settle();
    chk("end_loads_drained", exp_load.size(), 32'd0);
    chk("end_writes_drained", exp_wr.size(), 32'd0);
    chk("end_err_pulses", n_err_pulse, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
